keypad_entry_buffer: RTL
========================

# keypad_entry_buffer

Sits directly downstream of the keypad encoder and consumes its `code`/`valid` pair. It debounces the encoded key, turns each press into exactly one key event and assembles digit events into a fixed-length PIN. It presents the completed PIN to the lock controller with a valid/ack handshake. Key 10 is CLEAR (`*`), key 11 is ENTER (`#`), and keys 0–9 are digits.

## Interface
- `PIN_LEN`, default 4: digits per PIN (range 1–8).
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples needed to accept a new key state (≥1).
- `TIMEOUT_CYCLES`, default 1000: idle-entry timeout; used only with the macro in Configuration.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `code`  in  4  encoded key index from the encoder.
- `valid`  in  1  a key is pressed.
- `pin_ack`  in  1  consumer accepts the PIN; only meaningful while `pin_valid`=1.
- `pin`  out  4*PIN_LEN  PIN digits; first-entered digit in the MS nibble, last in nibble 0.
- `pin_valid`  out  1  completed PIN is held for the consumer.
- `digit_count`  out  4  digits currently buffered (0..PIN_LEN).
- `digit_strobe`  out  1  one-cycle pulse when a digit is accepted.
- `err_strobe`  out  1  one-cycle pulse on a rejected event.
- `timeout_strobe`  out  1  one-cycle pulse when a partial entry is discarded by timeout.

## Operation
- Reset (`rst_n`=0 at an edge) forces the following values. Reset mid-entry or mid-handshake discards all content.
  - `pin`=0, `pin_valid`=0, `digit_count`=0, all strobes 0.
  - State IDLE; debounced state "released"; debounce and timeout counters 0.
- Debounce:
  - The sample {`valid`,`code`} is compared with the previous cycle's sample; the stability counter resets on any difference.
  - When the sample has been identical for DEBOUNCE_CYCLES consecutive edges, it becomes the debounced state.
  - A key event fires once, on a debounced released→pressed transition.
  - Holding a key never repeats it. Changing code while held produces no event; the key must be released first.
  - While `valid`=0, `code` is ignored.
- Event decode:
  - Debounced pressed with `code` 12–15: no event, no error.
- States:
  - IDLE (count 0)
    - Digit → store, count=1, go to ENTRY.
    - CLEAR → no-op.
    - ENTER → `err_strobe`, stay in IDLE.
  - ENTRY (0<count<PIN_LEN)
    - Digit → shift left 4, insert into nibble 0, count+1. If count reaches PIN_LEN, go to FULL.
    - CLEAR → `pin`=0, count=0, go to IDLE.
    - ENTER → `err_strobe`, clear, go to IDLE.
  - FULL (count=PIN_LEN)
    - Digit → `err_strobe`, buffer unchanged.
    - CLEAR → clear, go to IDLE.
    - ENTER → `pin_valid`=1, go to READY.
  - READY
    - All key events are ignored, with no error pulse.
    - `pin` and `digit_count` are held stable.
    - `pin_ack`=1 at an edge → `pin_valid`=0, `pin`=0, count=0, go to IDLE.
- `pin_ack` outside READY has no effect.
- A key event and `pin_ack` in the same READY cycle: the ack is taken and the key event is dropped.
- Width rules:
  - `digit_count` is zero-extended to 4 bits.
  - `pin` nibbles above `digit_count` are 0.

## Timing
- Press latency: the input is stable from before edge 1.
  - Edge DEBOUNCE_CYCLES: debounced state updates.
  - Edge DEBOUNCE_CYCLES+1: buffer, count, state and strobe registers update.
  - Strobes are high for exactly that one following cycle.
- `pin_valid` rises at the ENTER update edge. It falls at the first edge where `pin_ack`=1.
- All outputs are registered; there is no combinational input→output path.
- A release must also be debounced for DEBOUNCE_CYCLES before the next press can generate an event.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - In ENTRY or FULL, a timeout counter increments each cycle and resets on every key event.
  - After TIMEOUT_CYCLES cycles with no event, at the next edge: clear, go to IDLE, pulse `timeout_strobe`.
  - No timeout in IDLE or READY.
- Undefined: no counter is built, `timeout_strobe` is tied to 0, and partial entries persist indefinitely.

## Test plan
- Digit entry: press 1,2,3,4 (each held 10 cycles, released 10) then ENTER → one `digit_strobe` per digit, `pin`=16'h1234, `pin_valid`=1. Then `pin_ack`=1 → next cycle `pin_valid`=0, `pin`=0, `digit_count`=0.
- Bounce rejection: `valid` toggling every cycle for 20 cycles with DEBOUNCE_CYCLES=4 → no strobes and `digit_count` stays 0. A single 3-cycle pulse also produces no event.
- Rejected events: 5,6 then ENTER → `err_strobe` once, `digit_count`=0. After 1,2,3,4, pressing 7 → `err_strobe`, `pin` stays 16'h1234.
- Hold and CLEAR: key 9 held 200 cycles → exactly one digit. Digits 9,8 then CLEAR → `pin`=0, `digit_count`=0.
- READY and reset: in READY press 5 → ignored, `pin` unchanged. Assert `rst_n`=0 during READY → next cycle all outputs are at reset values.
- Timeout (`KEYPAD_TIMEOUT_EN`, TIMEOUT_CYCLES=50): enter 3 digits and then idle → `timeout_strobe` pulses once, `digit_count`=0. Without the macro, `digit_count` stays 3.

Source files
------------

// File: rtl/keypad_entry_buffer.sv
// ============================================================================
// Module  : keypad_entry_buffer
// Brief   : Debounces keypad encoder output, assembles digit events into a
//           fixed-length PIN and hands it off with a valid/ack handshake.
//           Optional idle-entry timeout enabled by KEYPAD_TIMEOUT_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module keypad_entry_buffer #(
    parameter int PIN_LEN         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             code,
    input  logic                   valid,
    input  logic                   pin_ack,
    output logic [4*PIN_LEN-1:0]   pin,
    output logic                   pin_valid,
    output logic [3:0]             digit_count,
    output logic                   digit_strobe,
    output logic                   err_strobe,
    output logic                   timeout_strobe
);

    localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ENTRY = 2'd1;
    localparam logic [1:0] c_S_FULL  = 2'd2;
    localparam logic [1:0] c_S_READY = 2'd3;

    logic [4:0]            r_prev;
    logic [c_DB_W-1:0]     r_stab;
    logic                  r_deb_pressed;
    logic                  r_evt;
    logic [3:0]            r_evt_code;
    logic [1:0]            r_state;
    logic [4*PIN_LEN-1:0]  r_pin;
    logic [3:0]            r_count;
    logic                  r_pin_valid;
    logic                  r_dstb;
    logic                  r_estb;

    logic [4:0]            w_sample;
    logic [c_DB_W-1:0]     w_stab_next;
    logic                  w_stable;
    logic                  w_is_digit;
    logic                  w_is_clear;
    logic                  w_is_enter;
    logic [4*PIN_LEN-1:0]  w_shifted;
    logic [3:0]            w_count_inc;
    logic                  w_timeout;

    // Code is masked while released so code wiggles cannot restart the count.
    assign w_sample    = valid ? {1'b1, code} : 5'd0;
    assign w_stab_next = (w_sample != r_prev) ? c_DB_W'(1) :
                         (r_stab == c_DB_MAX) ? r_stab : r_stab + 1'b1;
    assign w_stable    = (w_stab_next == c_DB_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev        <= 5'd0;
            r_stab        <= '0;
            r_deb_pressed <= 1'b0;
            r_evt         <= 1'b0;
            r_evt_code    <= 4'd0;
        end else begin
            r_prev     <= w_sample;
            r_stab     <= w_stab_next;
            r_evt      <= w_stable & w_sample[4] & ~r_deb_pressed;
            r_evt_code <= w_sample[3:0];
            if (w_stable) begin
                r_deb_pressed <= w_sample[4];
            end
        end
    end

    assign w_is_digit  = r_evt && (r_evt_code <= 4'd9);
    assign w_is_clear  = r_evt && (r_evt_code == 4'd10);
    assign w_is_enter  = r_evt && (r_evt_code == 4'd11);
    assign w_shifted   = (r_pin << 4) | (4*PIN_LEN)'(r_evt_code);
    assign w_count_inc = r_count + 4'd1;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_tstb;
    logic              w_in_entry;

    assign w_in_entry = (r_state == c_S_ENTRY) || (r_state == c_S_FULL);
    assign w_timeout  = w_in_entry && !r_evt && (r_to_cnt == c_TO_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n || r_evt || !w_in_entry || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_tstb <= rst_n & w_timeout;
    end

    assign timeout_strobe = r_tstb;
`else
    // TIMEOUT_CYCLES is never negative, so this is a constant 0 that keeps the parameter referenced.
    assign w_timeout      = (TIMEOUT_CYCLES < 0);
    assign timeout_strobe = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_pin       <= '0;
            r_count     <= 4'd0;
            r_pin_valid <= 1'b0;
            r_dstb      <= 1'b0;
            r_estb      <= 1'b0;
        end else begin
            r_dstb <= 1'b0;
            r_estb <= 1'b0;
            if (w_timeout) begin
                r_pin   <= '0;
                r_count <= 4'd0;
                r_state <= c_S_IDLE;
            end else begin
                case (r_state)
                    c_S_IDLE, c_S_ENTRY: begin
                        if (w_is_digit) begin
                            r_pin   <= w_shifted;
                            r_count <= w_count_inc;
                            r_dstb  <= 1'b1;
                            r_state <= (w_count_inc == 4'(PIN_LEN)) ? c_S_FULL : c_S_ENTRY;
                        end else if (w_is_clear) begin
                            r_pin   <= '0;
                            r_count <= 4'd0;
                            r_state <= c_S_IDLE;
                        end else if (w_is_enter) begin
                            r_estb  <= 1'b1;
                            r_pin   <= '0;
                            r_count <= 4'd0;
                            r_state <= c_S_IDLE;
                        end
                    end
                    c_S_FULL: begin
                        if (w_is_digit) begin
                            r_estb <= 1'b1;
                        end else if (w_is_clear) begin
                            r_pin   <= '0;
                            r_count <= 4'd0;
                            r_state <= c_S_IDLE;
                        end else if (w_is_enter) begin
                            r_pin_valid <= 1'b1;
                            r_state     <= c_S_READY;
                        end
                    end
                    default: begin
                        // Key events are dropped here; only the ack moves us on.
                        if (pin_ack) begin
                            r_pin_valid <= 1'b0;
                            r_pin       <= '0;
                            r_count     <= 4'd0;
                            r_state     <= c_S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign pin          = r_pin;
    assign pin_valid    = r_pin_valid;
    assign digit_count  = r_count;
    assign digit_strobe = r_dstb;
    assign err_strobe   = r_estb;

endmodule

`default_nettype wire
